// File: rtl/expansor_vizinhos.sv
// expansor_vizinhos: scans the neighbour slots of one graph node, relaxes the
// tentative distance of each open neighbour and emits update/deactivate
// commands for the active-node evaluator.
// Optional feature: define EXPANSOR_CONTADOR_EN to add num_atualizacoes_out,
// the number of updates issued by the most recent expansion.
module expansor_vizinhos #(
  parameter int NUM_NA          = 4,
  parameter int ADR_WIDTH       = $clog2(NUM_NA),
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4,
  parameter int MAX_VIZINHOS    = 4,
  localparam int VIZ_WIDTH      = $clog2(MAX_VIZINHOS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           iniciar_in,
  input  logic [ADR_WIDTH-1:0]           no_atual_in,
  input  logic [DISTANCIA_WIDTH-1:0]     distancia_atual_in,
  output logic [ADR_WIDTH+VIZ_WIDTH-1:0] vizinho_adr_out,
  input  logic                           vizinho_valido_in,
  input  logic [ADR_WIDTH-1:0]           vizinho_endereco_in,
  input  logic [CUSTO_WIDTH-1:0]         vizinho_custo_in,
  output logic [ADR_WIDTH-1:0]           distancia_adr_out,
  input  logic [DISTANCIA_WIDTH-1:0]     distancia_lida_in,
  input  logic                           visitado_in,
  output logic                           atualizar_out,
  output logic                           desativar_out,
  output logic [ADR_WIDTH-1:0]           endereco_out,
  output logic [ADR_WIDTH-1:0]           anterior_out,
  output logic [DISTANCIA_WIDTH-1:0]     distancia_out,
  output logic [CUSTO_WIDTH-1:0]         menor_vizinho_out,
  output logic                           ocupado_out,
  output logic                           pronto_out
`ifdef EXPANSOR_CONTADOR_EN
  ,
  output logic [VIZ_WIDTH:0]             num_atualizacoes_out
`endif
);

  typedef enum logic [2:0] {
    OCIOSO,
    LER_VIZ,
    LER_DIST,
    AVALIAR,
    DESATIVAR,
    FIM
  } estado_t;

  estado_t estado;
  estado_t prox_estado;

  logic [ADR_WIDTH-1:0]       no_atual;
  logic [DISTANCIA_WIDTH-1:0] distancia_atual;
  logic [VIZ_WIDTH-1:0]       slot;
  logic [ADR_WIDTH-1:0]       vizinho;
  logic [CUSTO_WIDTH-1:0]     custo;
  logic [DISTANCIA_WIDTH:0]   soma;
  logic                       ultimo_slot;
  logic                       atualiza;

  // Relaxation test: one extra bit catches overflow of the accumulated distance
  always_comb begin
    soma        = {1'b0, distancia_atual} + (DISTANCIA_WIDTH+1)'(custo);
    ultimo_slot = (slot == VIZ_WIDTH'(MAX_VIZINHOS - 1));
    atualiza    = (estado == AVALIAR) &&
                  !soma[DISTANCIA_WIDTH] &&
                  (soma < {1'b0, distancia_lida_in}) &&
                  !visitado_in &&
                  (vizinho != no_atual);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  // Next-state logic: three cycles per neighbour, scan stops at an empty slot or the last slot
  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:    if (iniciar_in) prox_estado = LER_VIZ;
      LER_VIZ:   prox_estado = LER_DIST;
      LER_DIST:  prox_estado = vizinho_valido_in ? AVALIAR : DESATIVAR;
      AVALIAR:   prox_estado = ultimo_slot ? DESATIVAR : LER_VIZ;
      DESATIVAR: prox_estado = FIM;
      FIM:       prox_estado = OCIOSO;
      default:   prox_estado = OCIOSO;
    endcase
  end

  // Expansion context: node and distance captured at start, neighbour data captured per slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      no_atual        <= '0;
      distancia_atual <= '0;
      slot            <= '0;
      vizinho         <= '0;
      custo           <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (iniciar_in) begin
            no_atual        <= no_atual_in;
            distancia_atual <= distancia_atual_in;
            slot            <= '0;
          end
        end
        LER_DIST: begin
          if (vizinho_valido_in) begin
            vizinho <= vizinho_endereco_in;
            custo   <= vizinho_custo_in;
          end
        end
        AVALIAR: begin
          if (!ultimo_slot) begin
            slot <= slot + VIZ_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered command bus: every field returns to zero when no command is pulsed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      atualizar_out     <= 1'b0;
      desativar_out     <= 1'b0;
      endereco_out      <= '0;
      anterior_out      <= '0;
      distancia_out     <= '0;
      menor_vizinho_out <= '0;
    end else begin
      atualizar_out     <= 1'b0;
      desativar_out     <= 1'b0;
      endereco_out      <= '0;
      anterior_out      <= '0;
      distancia_out     <= '0;
      menor_vizinho_out <= '0;
      if (atualiza) begin
        atualizar_out     <= 1'b1;
        endereco_out      <= vizinho;
        anterior_out      <= no_atual;
        distancia_out     <= soma[DISTANCIA_WIDTH-1:0];
        menor_vizinho_out <= custo;
      end else if (estado == DESATIVAR) begin
        desativar_out <= 1'b1;
        endereco_out  <= no_atual;
      end
    end
  end

`ifdef EXPANSOR_CONTADOR_EN
  // Update counter: cleared on start, holds its final value until the next start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_atualizacoes_out <= '0;
    end else if (estado == OCIOSO && iniciar_in) begin
      num_atualizacoes_out <= '0;
    end else if (atualiza) begin
      num_atualizacoes_out <= num_atualizacoes_out + (VIZ_WIDTH+1)'(1);
    end
  end
`endif

  // Memory addresses and status flags decoded from the current state
  always_comb begin
    vizinho_adr_out   = {no_atual, slot};
    distancia_adr_out = (estado == LER_DIST) ? vizinho_endereco_in : '0;
    ocupado_out       = (estado != OCIOSO);
    pronto_out        = (estado == FIM);
  end

endmodule

// File: doc/expansor_vizinhos.md
EXPANSOR_VIZINHOS -- requirements
Module: expansor_vizinhos

Interface
REQ-001 SHALL have parameter NUM_NA, default 4: number of graph nodes.
REQ-002 SHALL have parameter ADR_WIDTH, default $clog2(NUM_NA): node address width.
REQ-003 SHALL have parameter DISTANCIA_WIDTH, default 5: accumulated distance width.
REQ-004 SHALL have parameter CUSTO_WIDTH, default 4: edge cost width.
REQ-005 SHALL have parameter MAX_VIZINHOS, default 4: neighbour slots per node; VIZ_WIDTH = $clog2(MAX_VIZINHOS).
REQ-006 Ports SHALL be:
 clk  in  1  single clock, rising edge
 rst_n  in  1  reset, asynchronous, active-low
 iniciar_in  in  1  start-expansion pulse
 no_atual_in  in  ADR_WIDTH  node being expanded
 distancia_atual_in  in  DISTANCIA_WIDTH  distance of no_atual
 vizinho_adr_out  out  ADR_WIDTH+VIZ_WIDTH  neighbour memory address {no, slot}
 vizinho_valido_in  in  1  slot holds a neighbour
 vizinho_endereco_in  in  ADR_WIDTH  neighbour node
 vizinho_custo_in  in  CUSTO_WIDTH  edge cost
 distancia_adr_out  out  ADR_WIDTH  distance memory address
 distancia_lida_in  in  DISTANCIA_WIDTH  stored distance of neighbour
 visitado_in  in  1  neighbour already closed
 atualizar_out  out  1  update command pulse to the active-node evaluator
 desativar_out  out  1  deactivate command pulse
 endereco_out  out  ADR_WIDTH  command target node
 anterior_out  out  ADR_WIDTH  predecessor (= no_atual)
 distancia_out  out  DISTANCIA_WIDTH  new tentative distance
 menor_vizinho_out  out  CUSTO_WIDTH  edge cost used for the update
 ocupado_out  out  1  expansion in progress
 pronto_out  out  1  one-cycle done pulse

Function
REQ-007 FSM states SHALL be OCIOSO, LER_VIZ, LER_DIST, AVALIAR, DESATIVAR, FIM.
REQ-008 In OCIOSO, iniciar_in=1 SHALL latch no_atual_in and distancia_atual_in, clear slot index, go LER_VIZ; iniciar_in SHALL be ignored in every other state.
REQ-009 LER_VIZ SHALL drive vizinho_adr_out={no_atual, slot}; memory data SHALL be sampled one cycle later in LER_DIST.
REQ-010 In LER_DIST, vizinho_valido_in=0 SHALL end the neighbour scan (go DESATIVAR); otherwise drive distancia_adr_out=vizinho_endereco_in, latch neighbour and cost, go AVALIAR.
REQ-011 In AVALIAR, soma = distancia_atual + custo SHALL be computed at DISTANCIA_WIDTH+1 bits; an update SHALL be issued iff soma < distancia_lida_in, soma has no carry out, visitado_in=0, and neighbour != no_atual.
REQ-012 An update SHALL assert atualizar_out for exactly the cycle after AVALIAR, with endereco_out=neighbour, anterior_out=no_atual, distancia_out=soma[DISTANCIA_WIDTH-1:0], menor_vizinho_out=custo.
REQ-013 After AVALIAR, slot SHALL increment and FSM go LER_VIZ; if slot was MAX_VIZINHOS-1, go DESATIVAR (no wrap).
REQ-014 Per-neighbour latency SHALL be 3 cycles; command outputs SHALL be registered and zero whenever no command is pulsed.
REQ-015 DESATIVAR SHALL pulse desativar_out for one cycle with endereco_out=no_atual, then go FIM.
REQ-016 FIM SHALL pulse pronto_out for one cycle and return to OCIOSO; ocupado_out SHALL be 1 in all states except OCIOSO.
REQ-017 atualizar_out and desativar_out SHALL never be asserted in the same cycle.

Reset
REQ-018 rst_n=0 SHALL immediately force FSM to OCIOSO and all outputs, latched node, distance and slot to 0.
REQ-019 Reset mid-expansion SHALL abort with no further atualizar_out, desativar_out or pronto_out.

Configuration
REQ-020 With macro EXPANSOR_CONTADOR_EN defined, SHALL add output num_atualizacoes_out [VIZ_WIDTH:0], cleared on start, incremented per atualizar_out pulse, held valid from pronto_out until next start; without it, the port and counter SHALL not exist and behaviour is otherwise identical.

Verification
REQ-021 no_atual=1, dist=5, slots {(2,c3),(3,c1),invalid}, stored dist 31,31 -> atualizar (end 2,ant 1,dist 8,cost 3) then (end 3,dist 6,cost 1), desativar end 1, pronto.
REQ-022 Stored dist of neighbour 2 = 8, soma 8 -> no update (strict less-than); desativar still issued.
REQ-023 dist=30, cost 4 (carry out) with stored 31 -> no update.
REQ-024 Neighbour visitado_in=1 or neighbour==no_atual -> skipped; all 4 slots valid -> scan ends after slot 3 without wrap.
REQ-025 rst_n low during AVALIAR of slot 1 -> outputs 0 asynchronously, no desativar/pronto; iniciar_in during busy ignored.
REQ-026 With EXPANSOR_CONTADOR_EN, scenario REQ-021 -> num_atualizacoes_out=2 at pronto.
